// File: rtl/motor_pkg.sv
// motor_pkg: state encodings and default widths shared by the soft motor driver.
package motor_pkg;
   localparam int STATE_W      = 3;
   localparam int PWM_BITS_DEF = 8;
   localparam int DUTY_MAX_DEF = 255;
   typedef enum logic [STATE_W-1:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      RUN       = 3'd2,
      RAMP_DOWN = 3'd3,
      LOCKOUT   = 3'd4
   } state_e;
endpackage

// File: rtl/motor_pwm_gen.sv
// motor_pwm_gen: glitch-free PWM; duty is latched into a shadow register only at period start.
// With MOTOR_BRAKE_EN an idle flag reports that the output cannot go high this period.
module motor_pwm_gen import motor_pkg::*; #(
   parameter int PWM_BITS = PWM_BITS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PWM_BITS-1:0] duty_i,
   input  logic                force_zero_i,
`ifdef MOTOR_BRAKE_EN
   output logic                idle_o,
`endif
   output logic                pwm_o
);
   logic [PWM_BITS-1:0] cnt_q, shadow_q, shadow_d;
   logic                pwm_q, pwm_d;
   always_comb begin
      shadow_d = force_zero_i ? '0 : (cnt_q == '0) ? duty_i : shadow_q;
      pwm_d    = !force_zero_i && (cnt_q < shadow_d);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_q + 1'b1;
         shadow_q <= shadow_d;
         pwm_q    <= pwm_d;
      end
   assign pwm_o = pwm_q;
`ifdef MOTOR_BRAKE_EN
   assign idle_o = !pwm_q && (shadow_q == '0);
`endif
endmodule

// File: rtl/motor_soft_driver.sv
// motor_soft_driver: soft-start/soft-stop PWM motor driver with stop lockout.
// Define MOTOR_BRAKE_EN to add the brake_out port and post-stop brake hold.
module motor_soft_driver import motor_pkg::*; #(
   parameter int PWM_BITS = PWM_BITS_DEF,
   parameter int DUTY_MAX = DUTY_MAX_DEF,
   parameter int RAMP_DIV = 100000
`ifdef MOTOR_BRAKE_EN
   , parameter int BRAKE_TICKS = 50
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_on,
   input  logic                stop,
   output logic                pwm_out,
   output logic                running,
   output logic [1:0]          state,
   output logic [PWM_BITS-1:0] duty
`ifdef MOTOR_BRAKE_EN
   , output logic              brake_out
`endif
);
   localparam int TW = $clog2(RAMP_DIV);
   localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(DUTY_MAX);
   state_e              state_q, state_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [TW-1:0]       tick_q, tick_d;
   logic                tick;
   always_comb begin
      tick    = tick_q == TW'(RAMP_DIV - 1);
      tick_d  = tick ? '0 : tick_q + 1'b1;
      state_d = state_q;
      duty_d  = duty_q;
      // Direction changes are tested before the tick so a coinciding tick never moves duty.
      if (stop) begin
         state_d = LOCKOUT;
         duty_d  = '0;
      end else
         case (state_q)
            IDLE:    if (cmd_on) state_d = RAMP_UP;
            RAMP_UP:
               if (!cmd_on) state_d = RAMP_DOWN;
               else if (duty_q >= DMAX) begin
                  state_d = RUN;
                  duty_d  = DMAX;
               end else if (tick) begin
                  duty_d  = duty_q + 1'b1;
                  state_d = (duty_d == DMAX) ? RUN : RAMP_UP;
               end
            RUN: begin
               duty_d  = DMAX;
               state_d = cmd_on ? RUN : RAMP_DOWN;
            end
            RAMP_DOWN:
               if (cmd_on) state_d = RAMP_UP;
               else if (duty_q == '0) state_d = IDLE;
               else if (tick) begin
                  duty_d  = duty_q - 1'b1;
                  state_d = (duty_d == '0) ? IDLE : RAMP_DOWN;
               end
            LOCKOUT: begin
               duty_d  = '0;
               state_d = cmd_on ? LOCKOUT : IDLE;
            end
            default: begin
               state_d = IDLE;
               duty_d  = '0;
            end
         endcase
   end
`ifdef MOTOR_BRAKE_EN
   localparam int BW = $clog2(BRAKE_TICKS + 1);
   logic [BW-1:0] brake_q, brake_d;
   logic          pwm_idle;
   // The hold only counts down once the last PWM period has drained.
   always_comb
      brake_d = (state_d != IDLE) ? '0
              : (state_q == RAMP_DOWN) ? BW'(BRAKE_TICKS)
              : (tick && pwm_idle && brake_q != '0) ? brake_q - 1'b1 : brake_q;
   assign brake_out = pwm_idle && (state_q == LOCKOUT || brake_q != '0);
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         duty_q  <= '0;
         tick_q  <= '0;
`ifdef MOTOR_BRAKE_EN
         brake_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         tick_q  <= tick_d;
`ifdef MOTOR_BRAKE_EN
         brake_q <= brake_d;
`endif
      end
   motor_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
      .clk          (clk),
      .rst_n        (reset),
      .duty_i       (duty_q),
      .force_zero_i (stop),
`ifdef MOTOR_BRAKE_EN
      .idle_o       (pwm_idle),
`endif
      .pwm_o        (pwm_out)
   );
   assign state   = (state_q == LOCKOUT) ? 2'd0 : state_q[1:0];
   assign running = state_q == RAMP_UP || state_q == RUN || state_q == RAMP_DOWN;
   assign duty    = duty_q;
endmodule

// File: tb/tb_motor_soft_driver.sv
// tb_motor_soft_driver: directed checks of ramp, stop lockout, PWM shape and async reset.
module tb_motor_soft_driver;
   logic       clk = 1'b0, reset = 1'b0, cmd_on = 1'b0, stop = 1'b0;
   logic       pwm_out, running;
   logic [1:0] state;
   logic [3:0] duty;
`ifdef MOTOR_BRAKE_EN
   logic       brake_out;
`endif
   int n_tot = 0, n_bad = 0;
   int hi [5] = '{0, 0, 0, 0, 0};
   int hi_exp [5] = '{0, 4, 8, 12, 15};
   int ok_run, cnt;
   always #5 clk = ~clk;
   motor_soft_driver #(
      .PWM_BITS(4), .DUTY_MAX(15), .RAMP_DIV(4)
`ifdef MOTOR_BRAKE_EN
      , .BRAKE_TICKS(3)
`endif
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_on    (cmd_on),
      .stop      (stop),
      .pwm_out   (pwm_out),
      .running   (running),
      .state     (state),
      .duty      (duty)
`ifdef MOTOR_BRAKE_EN
      , .brake_out (brake_out)
`endif
   );
   task automatic check(input string tag, input int act, input int exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wait_duty(input int v, input int lim, input string tag);
      int k = 0;
      while (k < lim && int'(duty) != v) begin
         step(1);
         k++;
      end
      check(tag, int'(duty), v);
   endtask
   task automatic wait_state(input int v, input int lim, input string tag);
      int k = 0;
      while (k < lim && int'(state) != v) begin
         step(1);
         k++;
      end
      check(tag, int'(state), v);
   endtask
   initial begin
      step(2);
      check("rst_state", state, 0);
      check("rst_duty", duty, 0);
      check("rst_pwm", pwm_out, 0);
      check("rst_running", running, 0);
      reset  = 1'b1;
      cmd_on = 1'b1;
      ok_run = 1;
      for (int k = 1; k <= 80; k++) begin
         step(1);
         hi[(k - 1) / 16] += int'(pwm_out);
         if (!running) ok_run = 0;
         if (k == 1) begin
            check("start_state", state, 1);
            check("start_duty", duty, 0);
         end
         if (k == 4) check("first_tick_duty", duty, 1);
         if (k == 59) begin
            check("pre_max_duty", duty, 14);
            check("pre_max_state", state, 1);
         end
         if (k == 60) begin
            check("max_duty", duty, 15);
            check("run_state", state, 2);
         end
      end
      check("running_ramp", ok_run, 1);
      for (int p = 0; p < 5; p++) check($sformatf("pwm_period%0d", p), hi[p], hi_exp[p]);
      // soft stop from RUN: 15 ticks down
      cmd_on = 1'b0;
      step(1);
      check("down_state", state, 3);
      check("down_duty", duty, 15);
      step(59);
      check("down_idle_state", state, 0);
      check("down_idle_duty", duty, 0);
      check("down_idle_running", running, 0);
`ifdef MOTOR_BRAKE_EN
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         step(1);
         cnt += int'(brake_out);
      end
      check("brake_hold_len_ok", int'(cnt >= 8 && cnt <= 12), 1);
      check("brake_hold_end", brake_out, 0);
`else
      step(16);
`endif
      cnt = 0;
      for (int k = 0; k < 32; k++) begin
         step(1);
         cnt += int'(pwm_out);
      end
      check("pwm_duty0", cnt, 0);
      // direction change coinciding with a tick
      cmd_on = 1'b1;
      wait_duty(7, 60, "reach_duty7");
      step(3);
      cmd_on = 1'b0;
      step(1);
      check("rev_state", state, 3);
      check("rev_duty_held", duty, 7);
      step(4);
      check("rev_first_tick", duty, 6);
      step(23);
      check("rev_last_state", state, 3);
      check("rev_last_duty", duty, 1);
      step(1);
      check("rev_idle_state", state, 0);
      check("rev_idle_duty", duty, 0);
      check("rev_idle_running", running, 0);
      // stop in RUN, lockout until command released
      cmd_on = 1'b1;
      wait_state(2, 80, "reach_run");
      stop = 1'b1;
      step(1);
      check("stop_state", state, 0);
      check("stop_running", running, 0);
      check("stop_duty", duty, 0);
      check("stop_pwm", pwm_out, 0);
`ifdef MOTOR_BRAKE_EN
      check("lock_brake", brake_out, 1);
`endif
      step(1);
      check("stop_pwm2", pwm_out, 0);
      stop = 1'b0;
      step(4);
      check("lock_state", state, 0);
      check("lock_running", running, 0);
`ifdef MOTOR_BRAKE_EN
      check("lock_brake2", brake_out, 1);
`endif
      cmd_on = 1'b0;
      step(1);
      check("unlock_state", state, 0);
`ifdef MOTOR_BRAKE_EN
      check("unlock_brake", brake_out, 0);
`endif
      cmd_on = 1'b1;
      step(1);
      check("rearm_state", state, 1);
      check("rearm_duty", duty, 0);
      // RAMP_DOWN back to RAMP_UP without discontinuity
      wait_duty(3, 20, "reach_duty3");
      cmd_on = 1'b0;
      step(1);
      check("dn_state", state, 3);
      check("dn_duty", duty, 3);
      wait_duty(2, 8, "reach_duty2");
      cmd_on = 1'b1;
      step(1);
      check("up_again_state", state, 1);
      check("up_again_duty", duty, 2);
      step(4);
      check("up_again_tick", duty, 3);
      // async reset mid-ramp
      wait_duty(9, 40, "reach_duty9");
      #2 reset = 1'b0;
      #1;
      check("arst_state", state, 0);
      check("arst_duty", duty, 0);
      check("arst_pwm", pwm_out, 0);
      check("arst_running", running, 0);
`ifdef MOTOR_BRAKE_EN
      check("arst_brake", brake_out, 0);
`endif
      @(negedge clk);
      reset = 1'b1;
      step(1);
      check("rel_state", state, 1);
      check("rel_duty", duty, 0);
      step(3);
      check("rel_tick_duty", duty, 1);
`ifdef MOTOR_BRAKE_EN
      cmd_on = 1'b0;
      wait_state(0, 20, "brk_idle");
      cnt = 0;
      while (cnt < 20 && !brake_out) begin
         step(1);
         cnt++;
      end
      check("brk_rise", brake_out, 1);
      cmd_on = 1'b1;
      step(1);
      check("brk_cancel", brake_out, 0);
      check("brk_cancel_state", state, 1);
`endif
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
